rf_access_arbiter: RTL and testbench
====================================

RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter ADDR_W, 3, register address width (8 registers).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req[1:0]  input  2  per-requester access request (0 = control unit, 1 = debug port); held high until done.
REQ-006 op0/op1  input  2 each  operation: 00 READ, 01 WRITE, 10 MOVE, 11 reserved.
REQ-007 src0/src1, dst0/dst1  input  ADDR_W each  source and destination register addresses.
REQ-008 wdata0/wdata1  input  DATA_W each  write data for WRITE.
REQ-009 gnt[1:0]  output  2  one-hot; marks the requester owning the current operation.
REQ-010 done[1:0]  output  2  one-cycle completion pulse to the granted requester.
REQ-011 err  output  1  high with done when the latched op was reserved.
REQ-012 rdata  output  DATA_W  READ result; valid while done is high, held until the next READ.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 rf_addr  output  ADDR_W  register file address.
REQ-015 R_L  output  1  register file load (write) enable.
REQ-016 R_E  output  1  register file read enable.
REQ-017 rf_wdata  output  DATA_W  register file write data.
REQ-018 rf_rdata  input  DATA_W  register file combinational read data.

Function
REQ-019 FSM states: IDLE, RD, WR, MV_RD, MV_WR, DONE.
REQ-020 In IDLE with any req high: arbitrate, latch op/src/dst/wdata of the winner, set gnt, and go to RD/WR/MV_RD by op; reserved op goes straight to DONE.
REQ-021 Arbitration is round-robin: a lone requester wins; on a tie the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-022 RD: R_E=1, rf_addr=src; rf_rdata captured into rdata at the cycle end; next state DONE.
REQ-023 WR: R_L=1, rf_addr=dst, rf_wdata=latched wdata; next state DONE.
REQ-024 MV_RD: R_E=1, rf_addr=src; rf_rdata captured into an internal temp register; next state MV_WR.
REQ-025 MV_WR: R_L=1, rf_addr=dst, rf_wdata=temp; next state DONE.
REQ-026 DONE: done[granted]=1 for exactly one cycle; err=1 if op was reserved; next state IDLE; gnt clears on entry to IDLE.
REQ-027 Outputs R_L, R_E, rf_addr and rf_wdata are Moore functions of state and latched fields; R_L and R_E are never both high; both are 0 in IDLE and DONE.
REQ-028 Latency from the IDLE cycle with req high to the done pulse: 2 cycles for READ/WRITE, 3 for MOVE, 1 for reserved.
REQ-029 Back-to-back: a new grant is possible in the IDLE cycle immediately after DONE; no requester is granted twice in a row while the other requests.
REQ-030 Dropping req mid-operation does not abort the operation; done still pulses.
REQ-031 MOVE with src == dst rewrites the same value; no special case.
REQ-032 Input changes after the grant cycle do not affect the operation in flight.

Reset
REQ-033 Reset forces IDLE immediately and asynchronously.
REQ-034 Reset values: gnt, done, err, busy, R_L and R_E are 0; rf_addr, rf_wdata, rdata and temp are 0; the last-grant pointer is 1.
REQ-035 Reset asserted during WR or MV_WR deasserts R_L combinationally with reset, so no write issues at the next edge.

Structure
REQ-036 A shared package holds the op encodings (OP_READ, OP_WRITE, OP_MOVE, OP_RSVD), the FSM state encodings, and DATA_W/ADDR_W defaults.
REQ-037 Round-robin selection is one sub-module, rr_arbiter2 (req[1:0], last pointer in, one-hot grant out); everything else is flat.

Verification
REQ-038 Requester 0 WRITE dst=3, wdata=16'hA5A5 -> R_L high for exactly one cycle with rf_addr=3; done[0] 2 cycles after the request; a subsequent READ src=3 returns rdata=16'hA5A5.
REQ-039 Reg1=16'h1234, requester 1 MOVE src=1 dst=6 -> R_E then R_L in consecutive cycles; reg6=16'h1234; done[1] at cycle 3.
REQ-040 Both requesters hold READ continuously after reset -> grants alternate 0,1,0,1; each done pulses only to its owner.
REQ-041 Requester 0 op=11 -> done[0] and err pulse 1 cycle later; R_L and R_E stay 0 throughout.
REQ-042 Reset asserted in MV_WR -> R_L drops before the next edge; dst keeps its old value; busy=0; FSM is in IDLE.
REQ-043 Requester drops req in RD -> done still pulses and rdata is valid; no new grant while both reqs are low.

Source files
------------

// File: rtl/rf_access_arbiter_pkg.sv
// Shared encodings for the register-file access arbiter: operation codes,
// FSM states and default datapath widths.
package rf_access_arbiter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        MV_RD = 3'd3,
        MV_WR = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Arbitrates two requesters onto a single-port register file and sequences
// READ, WRITE and MOVE (read-then-write) operations through a small FSM.
module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] src0,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] dst0,
    input  logic [ADDR_W-1:0] dst1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              R_L,
    output logic              R_E,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    state_e            state, state_nxt;
    op_e               op_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DATA_W-1:0] wdata_q, temp_q, rdata_q;
    logic [1:0]        gnt_q;
    logic              last_q;

    logic [1:0]        win;
    logic              win_idx;
    op_e               win_op;
    logic              start;

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last_q),
        .grant (win)
    );

    assign win_idx = win[1];
    assign win_op  = op_e'(win_idx ? op1 : op0);
    assign start   = (state == IDLE) && (|req);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    case (win_op)
                        OP_READ:  state_nxt = RD;
                        OP_WRITE: state_nxt = WR;
                        OP_MOVE:  state_nxt = MV_RD;
                        default:  state_nxt = DONE;
                    endcase
                end
            end
            RD, WR, MV_WR: state_nxt = DONE;
            MV_RD:         state_nxt = MV_WR;
            DONE:          state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    // Write enable is also gated by reset so an in-flight write cannot land on the next edge.
    always_comb begin
        R_E      = 1'b0;
        R_L      = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        case (state)
            RD, MV_RD: begin
                R_E     = 1'b1;
                rf_addr = src_q;
            end
            WR: begin
                R_L      = ~reset;
                rf_addr  = dst_q;
                rf_wdata = wdata_q;
            end
            MV_WR: begin
                R_L      = ~reset;
                rf_addr  = dst_q;
                rf_wdata = temp_q;
            end
            default: ;
        endcase
    end

    assign gnt   = gnt_q;
    assign done  = (state == DONE) ? gnt_q : 2'b00;
    assign err   = (state == DONE) && (op_q == OP_RSVD);
    assign busy  = (state != IDLE);
    assign rdata = rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_READ;
            src_q   <= '0;
            dst_q   <= '0;
            wdata_q <= '0;
            temp_q  <= '0;
            rdata_q <= '0;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (start) begin
                gnt_q   <= win;
                last_q  <= win_idx;
                op_q    <= win_op;
                src_q   <= win_idx ? src1 : src0;
                dst_q   <= win_idx ? dst1 : dst0;
                wdata_q <= win_idx ? wdata1 : wdata0;
            end else if (state == DONE) begin
                gnt_q <= 2'b00;
            end
            if (state == RD) begin
                rdata_q <= rf_rdata;
            end
            if (state == MV_RD) begin
                temp_q <= rf_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench: a transaction-level model predicts the round-robin
// winner, latency, strobes and register-file contents for random traffic.
module tb_rf_access_arbiter;
    import rf_access_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        preload;
    logic [1:0]  req_v;
    logic [1:0]  op_v    [2];
    logic [2:0]  src_v   [2];
    logic [2:0]  dst_v   [2];
    logic [15:0] wdata_v [2];

    logic [1:0]  gnt, done;
    logic        err, busy, r_l, r_e;
    logic [15:0] rdata, rf_wdata, rf_rdata;
    logic [2:0]  rf_addr;

    logic [15:0] rf       [8];
    logic [15:0] exp_regs [8];
    int          last_m;
    int          checks   = 0;
    int          failures = 0;

    rf_access_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req_v),
        .op0      (op_v[0]),
        .op1      (op_v[1]),
        .src0     (src_v[0]),
        .src1     (src_v[1]),
        .dst0     (dst_v[0]),
        .dst1     (dst_v[1]),
        .wdata0   (wdata_v[0]),
        .wdata1   (wdata_v[1]),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .rf_addr  (rf_addr),
        .R_L      (r_l),
        .R_E      (r_e),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(16'h1000 * i + 16'h0011 * i + 16'h0007);
    endfunction

    // Register file model driven by the DUT strobes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= init_val(i);
        end else if (r_l) begin
            rf[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf[rf_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_gnt",  32'(gnt),  32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_rl",   32'(r_l),  32'd0);
        check("idle_re",   32'(r_e),  32'd0);
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] s,
                           input logic [2:0] d, input logic [15:0] wd);
        op_v[i]    = o;
        src_v[i]   = s;
        dst_v[i]   = d;
        wdata_v[i] = wd;
        req_v[i]   = 1'b1;
    endtask

    // Called on a falling edge while the DUT is idle and at least one req is high.
    task automatic run_txn(input bit keep);
        int          w, lat, nl, ne;
        logic [1:0]  o;
        logic [2:0]  s, d;
        logic [15:0] wd, mv;
        w   = (req_v == 2'b11) ? 1 - last_m : (req_v[0] ? 0 : 1);
        o   = op_v[w];
        s   = src_v[w];
        d   = dst_v[w];
        wd  = wdata_v[w];
        mv  = exp_regs[s];
        lat = (o == OP_MOVE) ? 3 : (o == OP_RSVD) ? 1 : 2;
        nl  = 0;
        ne  = 0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'd1);
            check("gnt",  32'(gnt),  32'(1 << w));
            check("done", 32'(done), (k == lat) ? 32'(1 << w) : 32'd0);
            check("rl_re_excl", 32'(r_l & r_e), 32'd0);
            if (r_e) begin
                ne++;
                check("rd_addr", 32'(rf_addr), 32'(s));
            end
            if (r_l) begin
                nl++;
                check("wr_addr", 32'(rf_addr), 32'(d));
                check("wr_data", 32'(rf_wdata), 32'((o == OP_MOVE) ? mv : wd));
            end
            if (k == 1 && !keep) begin
                op_v[w]    = 2'($urandom_range(0, 3));
                src_v[w]   = 3'($urandom);
                dst_v[w]   = 3'($urandom);
                wdata_v[w] = 16'($urandom);
                if ($urandom_range(0, 1) == 1) req_v[w] = 1'b0;
            end
        end
        check("err", 32'(err), 32'(o == OP_RSVD));
        if (o == OP_READ) check("rdata", 32'(rdata), 32'(exp_regs[s]));
        check("n_write", 32'(nl), 32'(o == OP_WRITE || o == OP_MOVE));
        check("n_read",  32'(ne), 32'(o == OP_READ || o == OP_MOVE));
        if (o == OP_WRITE) exp_regs[d] = wd;
        else if (o == OP_MOVE) exp_regs[d] = mv;
        if (o == OP_WRITE || o == OP_MOVE) check("rf_content", 32'(rf[d]), 32'(exp_regs[d]));
        last_m = w;
        if (keep) begin
            op_v[w]  = OP_READ;
            src_v[w] = 3'($urandom);
        end else begin
            req_v[w] = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        req_v   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            op_v[i] = '0; src_v[i] = '0; dst_v[i] = '0; wdata_v[i] = '0;
        end
        for (int i = 0; i < 8; i++) exp_regs[i] = init_val(i);
        last_m = 1;
        repeat (2) @(negedge clk);

        check("rst_gnt",      32'(gnt),      32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_rl",       32'(r_l),      32'd0);
        check("rst_re",       32'(r_e),      32'd0);
        check("rst_rf_addr",  32'(rf_addr),  32'd0);
        check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        check("rst_rdata",    32'(rdata),    32'd0);
        preload = 1'b0;
        reset   = 1'b0;

        // Both requesters hold READ: grants must alternate starting with 0.
        set_req(0, OP_READ, 3'd2, 3'd0, 16'h0);
        set_req(1, OP_READ, 3'd5, 3'd0, 16'h0);
        for (int n = 0; n < 4; n++) begin
            check("tie_order", 32'(last_m), (n % 2 == 0) ? 32'd1 : 32'd0);
            run_txn(1);
            @(negedge clk);
            check_idle();
        end
        req_v = 2'b00;
        @(negedge clk);
        check_idle();

        set_req(0, OP_WRITE, 3'd0, 3'd3, 16'hA5A5);
        run_txn(0);
        @(negedge clk);
        check_idle();
        set_req(0, OP_READ, 3'd3, 3'd0, 16'h0);
        run_txn(0);
        check("rd_a5a5", 32'(rdata), 32'h0000A5A5);
        @(negedge clk);

        set_req(0, OP_WRITE, 3'd0, 3'd1, 16'h1234);
        run_txn(0);
        @(negedge clk);
        set_req(1, OP_MOVE, 3'd1, 3'd6, 16'h0);
        run_txn(0);
        check("mv_reg6", 32'(rf[6]), 32'h00001234);
        @(negedge clk);

        set_req(0, OP_RSVD, 3'd4, 3'd4, 16'hFFFF);
        run_txn(0);
        @(negedge clk);
        check_idle();

        // Reset in MV_WR must kill the write strobe immediately.
        set_req(1, OP_MOVE, 3'd2, 3'd5, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("mvwr_rl", 32'(r_l), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_rl",   32'(r_l),  32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_gnt",  32'(gnt),  32'd0);
        req_v = 2'b00;
        @(negedge clk);
        reset  = 1'b0;
        last_m = 1;
        check("rst_keep_dst", 32'(rf[5]), 32'(exp_regs[5]));
        check_idle();

        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            check_idle();
            for (int i = 0; i < 2; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 16'($urandom));
                end
            end
            if (req_v != 2'b00) run_txn(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
